// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier issue/retire controller.
package mul_pkg;

    localparam int WIDTH = 64;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        CLEAR = 2'b10
    } state_e;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Request, response and multiplier-side signals of the issue controller.
interface mul_issue_ctrl_if
    import mul_pkg::*;
;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_multiplier;
    logic [WIDTH-1:0]     in_multiplicand;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_result;
    logic [WIDTH-1:0]     mul_multiplier;
    logic [WIDTH-1:0]     mul_multiplicand;
    logic                 mul_op_start;
    logic                 mul_op_clear;
    logic                 mul_op_done;
    logic [2*WIDTH-1:0]   mul_result;
    logic                 busy;
    logic [CNT_W-1:0]     op_count;

    // Controller side.
    modport slave (
        input  in_valid, in_multiplier, in_multiplicand, out_ready,
               mul_op_done, mul_result,
        output in_ready, out_valid, out_result, mul_multiplier,
               mul_multiplicand, mul_op_start, mul_op_clear, busy, op_count
    );

    // System and multiplier side.
    modport master (
        output in_valid, in_multiplier, in_multiplicand, out_ready,
               mul_op_done, mul_result,
        input  in_ready, out_valid, out_result, mul_multiplier,
               mul_multiplicand, mul_op_start, mul_op_clear, busy, op_count
    );

endinterface

// File: rtl/mul_issue_ns_logic.sv
// Next-state and handshake decode for the multiplier issue controller.
module mul_issue_ns_logic
    import mul_pkg::*;
(
    input  state_e state_q,
    input  logic   in_valid_i,
    input  logic   mul_op_done_i,
    input  logic   out_valid_i,
    input  logic   out_ready_i,
    output state_e state_d,
    output logic   in_ready_o,
    output logic   op_start_o,
    output logic   op_clear_o,
    output logic   accept_o,
    output logic   capture_o
);

    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        op_start_o = 1'b0;
        op_clear_o = 1'b0;
        accept_o   = 1'b0;
        capture_o  = 1'b0;
        case (state_q)
            IDLE: begin
                // A lingering op_done means the multiplier has not finished clearing.
                in_ready_o = !mul_op_done_i;
                if (in_valid_i && !mul_op_done_i) begin
                    accept_o = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                op_start_o = 1'b1;
                // Retire only when the output slot is free or draining this cycle.
                if (mul_op_done_i && (!out_valid_i || out_ready_i)) begin
                    capture_o = 1'b1;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                op_clear_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/retire controller in front of the Booth multiplier, with a one-deep product register.
module mul_issue_ctrl
    import mul_pkg::*;
(
    input logic             clk,
    input logic             reset_n,
    mul_issue_ctrl_if.slave bus
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 accept, capture;
    logic                 in_ready, op_start, op_clear;

    mul_issue_ns_logic u_ns (
        .state_q       (state_q),
        .in_valid_i    (bus.in_valid),
        .mul_op_done_i (bus.mul_op_done),
        .out_valid_i   (out_valid_q),
        .out_ready_i   (bus.out_ready),
        .state_d       (state_d),
        .in_ready_o    (in_ready),
        .op_start_o    (op_start),
        .op_clear_o    (op_clear),
        .accept_o      (accept),
        .capture_o     (capture)
    );

    always_comb begin
        mplier_d    = mplier_q;
        mcand_d     = mcand_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        count_d     = count_q;
        if (accept) begin
            mplier_d = bus.in_multiplier;
            mcand_d  = bus.in_multiplicand;
        end
        // A reload in the same cycle as a drain keeps the slot full.
        if (capture) begin
            result_d    = bus.mul_result;
            out_valid_d = 1'b1;
            count_d     = count_q + CNT_W'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mplier_q    <= '0;
            mcand_q     <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            mplier_q    <= mplier_d;
            mcand_q     <= mcand_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign bus.in_ready         = in_ready;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_result       = result_q;
    assign bus.mul_multiplier   = mplier_q;
    assign bus.mul_multiplicand = mcand_q;
    assign bus.mul_op_start     = op_start;
    assign bus.mul_op_clear     = op_clear;
    assign bus.busy             = (state_q != IDLE);
    assign bus.op_count         = count_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomized bench for mul_issue_ctrl with a multiplier stand-in and a transaction-level model.
module tb_mul_issue_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mul_issue_ctrl_if ifc ();

    mul_issue_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    function automatic logic [127:0] smul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ax, bx;
        ax = {{64{a[63]}}, a};
        bx = {{64{b[63]}}, b};
        return ax * bx;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Multiplier stand-in: level op_start starts it, op_done holds until op_clear (plus optional linger).
    int           lat_cfg = 2;
    int           linger_cfg = 0;
    logic         e_done, e_busy;
    int           e_cnt, e_ling;
    logic [127:0] e_res;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_done <= 1'b0; e_busy <= 1'b0; e_cnt <= 0; e_ling <= 0; e_res <= '0;
        end else if (ifc.mul_op_clear) begin
            if (linger_cfg == 0) e_done <= 1'b0;
            else e_ling <= linger_cfg;
        end else if (e_ling != 0) begin
            e_ling <= e_ling - 1;
            if (e_ling == 1) e_done <= 1'b0;
        end else if (e_busy) begin
            if (e_cnt <= 1) begin
                e_done <= 1'b1;
                e_busy <= 1'b0;
                e_res  <= smul(ifc.mul_multiplier, ifc.mul_multiplicand);
            end else begin
                e_cnt <= e_cnt - 1;
            end
        end else if (ifc.mul_op_start && !e_done) begin
            e_busy <= 1'b1;
            e_cnt  <= lat_cfg;
        end
    end

    assign ifc.mul_op_done = e_done;
    assign ifc.mul_result  = e_res;

    // Transaction model: one outstanding op, a one-cycle clear phase, a one-deep product slot.
    logic         m_out, m_clr, m_ov;
    logic [63:0]  m_a, m_b;
    logic [127:0] m_prod, m_res;
    logic [15:0]  m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_out <= 1'b0; m_clr <= 1'b0; m_ov <= 1'b0;
            m_a <= '0; m_b <= '0; m_prod <= '0; m_res <= '0; m_cnt <= '0;
        end else begin
            logic acc, cap;
            acc = !m_out && !m_clr && !ifc.mul_op_done && ifc.in_valid;
            cap = m_out && ifc.mul_op_done && (!m_ov || ifc.out_ready);
            if (cap) begin
                m_ov  <= 1'b1;
                m_res <= m_prod;
                m_cnt <= m_cnt + 16'd1;
            end else if (m_ov && ifc.out_ready) begin
                m_ov <= 1'b0;
            end
            m_clr <= cap;
            if (cap) m_out <= 1'b0;
            else if (acc) m_out <= 1'b1;
            if (acc) begin
                m_a    <= ifc.in_multiplier;
                m_b    <= ifc.in_multiplicand;
                m_prod <= smul(ifc.in_multiplier, ifc.in_multiplicand);
            end
        end
    end

    logic [127:0] got[$];

    always @(negedge clk) begin
        chk("in_ready", 128'(ifc.in_ready), 128'(!m_out && !m_clr && !ifc.mul_op_done));
        chk("out_valid", 128'(ifc.out_valid), 128'(m_ov));
        chk("out_result", ifc.out_result, m_res);
        chk("op_start", 128'(ifc.mul_op_start), 128'(m_out));
        chk("op_clear", 128'(ifc.mul_op_clear), 128'(m_clr));
        chk("start_clear_excl", 128'(ifc.mul_op_start && ifc.mul_op_clear), 128'(0));
        chk("busy", 128'(ifc.busy), 128'(m_out || m_clr));
        chk("op_count", 128'(ifc.op_count), 128'(m_cnt));
        chk("mul_multiplier", 128'(ifc.mul_multiplier), 128'(m_a));
        chk("mul_multiplicand", 128'(ifc.mul_multiplicand), 128'(m_b));
        if (reset_n && ifc.out_valid && ifc.out_ready) got.push_back(ifc.out_result);
    end

    // out_ready: 0 = held low, 1 = held high, 2 = random each cycle.
    int rdy_mode = 1;
    initial begin
        ifc.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ifc.out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b);
        logic r;
        @(posedge clk);
        #1;
        ifc.in_valid        = 1'b1;
        ifc.in_multiplier   = a;
        ifc.in_multiplicand = b;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            r = ifc.in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ifc.in_valid = 1'b0;
                return;
            end
        end
        ifc.in_valid = 1'b0;
        chk("issue_timeout", 128'(0), 128'(1));
    endtask

    task automatic wait_got(input int n);
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (got.size() >= n) return;
        end
        chk("wait_product_timeout", 128'(got.size()), 128'(n));
    endtask

    initial begin
        int base;
        reset_n             = 1'b0;
        ifc.in_valid        = 1'b0;
        ifc.in_multiplier   = '0;
        ifc.in_multiplicand = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_op_count", 128'(ifc.op_count), 128'(0));
        chk("reset_in_ready", 128'(ifc.in_ready), 128'(1));
        reset_n = 1'b1;

        issue(64'd3, 64'd5);
        wait_got(1);
        chk("3x5", got[0], 128'd15);
        chk("3x5_count", 128'(ifc.op_count), 128'(1));

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        wait_got(2);
        chk("neg1x2", got[1], {{127{1'b1}}, 1'b0});

        rdy_mode = 0;
        issue(64'd7, 64'd9);
        issue(64'd4, 64'd4);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        chk("stall_valid", 128'(ifc.out_valid), 128'(1));
        chk("stall_held63", ifc.out_result, 128'd63);
        chk("stall_start", 128'(ifc.mul_op_start), 128'(1));
        chk("stall_done", 128'(ifc.mul_op_done), 128'(1));
        @(posedge clk);
        #1;
        rdy_mode = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain_retire_valid", 128'(ifc.out_valid), 128'(1));
        chk("drain_retire_16", ifc.out_result, 128'd16);
        wait_got(4);
        chk("order_63", got[2], 128'd63);
        chk("order_16", got[3], 128'd16);

        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (k % 8 == 1) a = 64'h8000_0000_0000_0000;
            if (k % 8 == 5) b = 64'hFFFF_FFFF_FFFF_FFFF;
            lat_cfg    = $urandom_range(1, 4);
            linger_cfg = $urandom_range(0, 2);
            issue(a, b);
        end
        rdy_mode = 1;
        wait_got(44);
        chk("random_count", 128'(got.size()), 128'(44));

        linger_cfg = 0;
        lat_cfg    = 8;
        issue(64'd11, 64'd13);
        chk("midrun_start", 128'(ifc.mul_op_start), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", 128'(ifc.out_valid), 128'(0));
        chk("rst_op_start", 128'(ifc.mul_op_start), 128'(0));
        chk("rst_op_clear", 128'(ifc.mul_op_clear), 128'(0));
        chk("rst_busy", 128'(ifc.busy), 128'(0));
        chk("rst_op_count", 128'(ifc.op_count), 128'(0));
        chk("rst_out_result", ifc.out_result, 128'd0);
        chk("rst_mul_multiplier", 128'(ifc.mul_multiplier), 128'(0));
        base = got.size();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        lat_cfg = 2;
        issue(64'd2, 64'd2);
        wait_got(base + 1);
        chk("post_rst_2x2", got[base], 128'd4);
        chk("post_rst_count", 128'(ifc.op_count), 128'(1));
        repeat (5) @(posedge clk);
        chk("post_rst_no_extra", 128'(got.size()), 128'(base + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Issue/retire controller directly upstream of the radix-2 Booth `multiplier` block. It accepts 64x64 operand pairs over a valid/ready request port and drives the multiplier's `op_start`/`op_clear` level protocol. It captures the 128-bit product into an output register and presents it over a valid/ready response port. The block owns all multiplier sequencing, so system logic never touches `op_start`, `op_clear` or `op_done` directly.

## Interface
- `WIDTH`, 64: operand width; product width is `2*WIDTH`. Fixed to match the multiplier.
- `CNT_W`, 16: width of the completed-operation counter.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request operand pair valid.
- `in_ready`  out  1  controller can accept a request.
- `in_multiplier`  in  WIDTH  signed operand.
- `in_multiplicand`  in  WIDTH  signed operand.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  consumer accepts the product.
- `out_result`  out  2*WIDTH  signed product.
- `mul_multiplier`  out  WIDTH  to multiplier; registered.
- `mul_multiplicand`  out  WIDTH  to multiplier; registered.
- `mul_op_start`  out  1  to multiplier `op_start`.
- `mul_op_clear`  out  1  to multiplier `op_clear`.
- `mul_op_done`  in  1  from multiplier `op_done`.
- `mul_result`  in  2*WIDTH  from multiplier `result`.
- `busy`  out  1  state != IDLE.
- `op_count`  out  CNT_W  retired-operation count; wraps modulo 2^CNT_W.

## Operation
FSM states and transitions:
- **IDLE**
  - `in_ready = !mul_op_done`.
  - On `in_valid && in_ready`: latch both operands into `mul_multiplier`/`mul_multiplicand`, go to RUN.
- **RUN**
  - `mul_op_start = 1`, `mul_op_clear = 0`.
  - Operand registers hold unchanged.
  - Waits for `mul_op_done = 1`.
  - If `mul_op_done && (!out_valid || out_ready)`: load `out_result <= mul_result`, set `out_valid`, increment `op_count`, go to CLEAR.
  - If `mul_op_done` but the output register is occupied and not draining: stay in RUN (stall). The multiplier holds `op_done` and `result` meanwhile.
- **CLEAR**
  - `mul_op_start = 0`, `mul_op_clear = 1` for exactly one cycle, then go to IDLE.

Output register:
- Clears `out_valid` on `out_valid && out_ready` unless it is reloaded in the same cycle; reload wins.
- Behaves as a one-deep skid stage, so a new operation can run while the previous product waits.

Arithmetic and misc:
- No arithmetic in this block. `out_result` is `mul_result` verbatim (two's complement).
- `mul_op_start` and `mul_op_clear` are never both 1.
- `in_ready` is 0 in RUN and CLEAR.

## Timing
Reset:
- Asynchronous on `reset_n = 0`: state IDLE.
- `out_valid`, `mul_op_start`, `mul_op_clear`, `busy`, `op_count`, `out_result`, `mul_multiplier`, `mul_multiplicand` all reset to 0.
- `in_ready` evaluates to `!mul_op_done`, which is 1 after the multiplier resets.

Latency and throughput:
- Request accept at edge N puts `mul_op_start` high from cycle N+1.
- `out_valid` rises one cycle after the first cycle in which `mul_op_done` is sampled high with the output register free.
- Back-to-back issue: the next `in_ready` comes two cycles after capture (CLEAR, then IDLE with `op_done` low).

Boundary conditions:
- **Simultaneous retire and drain:** the old product leaves, the new product loads, and `out_valid` stays 1.
- **Reset mid-RUN:** the in-flight operation is discarded and no product is emitted. The shared `reset_n` also resets the multiplier.
- **`mul_op_done` still high in IDLE:** `in_ready = 0` until it falls.
- **`op_count` wrap:** 0xFFFF + 1 = 0x0000.

## Structure
Shared package `mul_pkg` holds:
- `WIDTH` default.
- State encoding constants: IDLE = 2'b00, RUN = 2'b01, CLEAR = 2'b10.
- The 2-bit state typedef.

The block splits naturally into one sub-module, `mul_issue_ns_logic`, the combinational next-state and handshake decode. State, operand, result and counter registers live in the top, using the team's reset-register cells.

## Test plan
- Reset, then issue 3 x 5 -> `out_result = 128'd15`, `out_valid` asserts once, `op_count = 1`.
- Issue 64'hFFFF_FFFF_FFFF_FFFF (-1) x 2 -> `out_result = 128'hFFFF...FFFE` (-2).
- Hold `out_ready = 0` and issue two ops (7 x 9, then 4 x 4) -> first product 63 is held, controller stalls in RUN with `mul_op_start = 1`. Raise `out_ready` -> 63 then 16 delivered in order, none lost.
- Simultaneous drain and retire: `out_ready = 1` on the exact cycle `mul_op_done` rises -> `out_valid` stays 1 and the new product appears the next cycle.
- Assert `reset_n = 0` mid-RUN -> all outputs 0 immediately. After release, 2 x 2 yields 4 and `op_count = 1`.
- Check `mul_op_clear` is a single-cycle pulse after each capture, and `op_start`/`op_clear` are never high together.
